// File: rtl/fpmul_iter_radix.sv
// fpmul_iter_radix: iterative fixed-point multiplier retiring K multiplier bits per cycle.
//   Latency: operands accepted in IDLE; N/K BUSY cycles later the result is held in DONE.
//   Backpressure: snd_rdy only in IDLE; result held in DONE until rcv_rdy (no overlap).
// Ports: clk/reset_n (async active-low); snd_val/snd_rdy + a, b, rnd operand handshake;
//   rcv_val/rcv_rdy + c, ovf result handshake. c = bits [N+D-1:D] of the (rounded) product.
// Build option: define FPMUL_ITER_RADIX_SAT_EN to clamp c on overflow instead of wrapping.
module fpmul_iter_radix #(
  parameter int N    = 32,
  parameter int D    = 16,
  parameter int SIGN = 1,
  parameter int K    = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         snd_val,
  output logic         snd_rdy,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         rnd,
  output logic         rcv_val,
  input  logic         rcv_rdy,
  output logic [N-1:0] c,
  output logic         ovf
);
  localparam int W  = 2 * N;
  localparam int ND = N / K;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(ND - 1);
  localparam int RSH = (D > 0) ? D - 1 : 0;
  localparam logic [W-1:0] RND_INC = (D > 0) ? (W'(1) << RSH) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;

  logic [W-1:0]  acc_q;
  logic [W-1:0]  a_sh_q;   // multiplicand, pre-shifted to the weight of the current digit
  logic [N-1:0]  b_sh_q;   // multiplier, current digit always in the low K bits
  logic [CW-1:0] cnt_q;
  logic          rnd_q;
  logic          last_dig;
  logic [W-1:0]  pp, acc_nxt, pr, pr_sh;
  logic [N-1:0]  c_d;
  logic          ovf_d;

  assign snd_rdy  = (state_q == IDLE);
  assign rcv_val  = (state_q == DONE);
  assign last_dig = (cnt_q == LAST_DIG);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (snd_val) state_d = BUSY;
      BUSY:    if (last_dig) state_d = DONE;
      DONE:    if (rcv_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pp = a_sh_q * {{(W-K){1'b0}}, b_sh_q[K-1:0]};
    // Top digit of a signed multiplier: its MSB weighs -2^(K-1) within the digit,
    // i.e. the unsigned digit value minus 2^K.
    if (SIGN != 0 && last_dig && b_sh_q[K-1]) pp = pp - (a_sh_q << K);
    acc_nxt = acc_q + pp;
    // 2N bits hold the rounded product in both signednesses since D < N.
    pr = acc_nxt + (rnd_q ? RND_INC : '0);
    if (SIGN != 0) pr_sh = $unsigned($signed(pr) >>> D);
    else           pr_sh = pr >> D;
    c_d = pr_sh[N-1:0];
    if (SIGN != 0) ovf_d = !((&pr_sh[W-1:N-1]) | ~(|pr_sh[W-1:N-1]));
    else           ovf_d = |pr_sh[W-1:N];
`ifdef FPMUL_ITER_RADIX_SAT_EN
    if (ovf_d) begin
      if (SIGN == 0)    c_d = '1;
      else if (pr[W-1]) c_d = {1'b1, {(N-1){1'b0}}};
      else              c_d = {1'b0, {(N-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      state_q <= IDLE;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      rnd_q   <= 1'b0;
      c       <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (snd_val) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            rnd_q  <= rnd;
            b_sh_q <= b;
            a_sh_q <= (SIGN != 0) ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
          end
        end
        BUSY: begin
          acc_q  <= acc_nxt;
          a_sh_q <= a_sh_q << K;
          b_sh_q <= b_sh_q >> K;
          cnt_q  <= cnt_q + CW'(1);
          // Result registers load with the final digit so DONE presents it at once.
          if (last_dig) begin
            c   <= c_d;
            ovf <= ovf_d;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpmul_iter_radix.sv
module tb_fpmul_iter_radix;
  localparam int N    = 16;
  localparam int D    = 8;
  localparam int SIGN = 1;
  localparam int K    = 4;
  localparam int LAT  = N / K + 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         snd_val = 1'b0;
  logic         rnd = 1'b0;
  logic         rcv_rdy = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         snd_rdy, rcv_val, ovf;
  logic [N-1:0] c;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fpmul_iter_radix #(.N(N), .D(D), .SIGN(SIGN), .K(K)) dut (
    .clk(clk), .reset_n(reset_n), .snd_val(snd_val), .snd_rdy(snd_rdy),
    .a(a), .b(b), .rnd(rnd), .rcv_val(rcv_val), .rcv_rdy(rcv_rdy),
    .c(c), .ovf(ovf)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         rnd;
    logic [N-1:0] c_wrap;
    logic [N-1:0] c_sat;
    logic         ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, optional half-up bias, floor shift, range test.
  function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                input logic mr, output logic [N-1:0] mc, output logic mo);
    longint pa, pb, p, q, lo, hi;
    pa = (SIGN != 0) ? longint'($signed(ma)) : longint'(ma);
    pb = (SIGN != 0) ? longint'($signed(mb)) : longint'(mb);
    p = pa * pb;
    if (mr && D > 0) p = p + (longint'(1) << (D - 1));
    q = p >>> D;
    lo = (SIGN != 0) ? -(longint'(1) << (N - 1)) : 0;
    hi = (SIGN != 0) ? (longint'(1) << (N - 1)) - 1 : (longint'(1) << N) - 1;
    mo = (q < lo) || (q > hi);
    mc = q[N-1:0];
`ifdef FPMUL_ITER_RADIX_SAT_EN
    if (mo) begin
      if (SIGN == 0)  mc = '1;
      else if (q < 0) mc = lo[N-1:0];
      else            mc = hi[N-1:0];
    end
`endif
  endfunction

  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tr,
                       input int hold, output logic [N-1:0] rc, output logic ro,
                       output int lat);
    int w;
    w = 0;
    while (!snd_rdy && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("snd_rdy_before_issue", 32'(snd_rdy), 32'd1);
    a = ta; b = tb; rnd = tr; snd_val = 1'b1;
    @(posedge clk); #1;
    // Scramble operand inputs: they must be ignored once the operation is in flight.
    snd_val = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    rnd = 1'($urandom);
    lat = 1;
    while (!rcv_val && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rc = c;
    ro = ovf;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    rcv_rdy = 1'b1;
    @(posedge clk); #1;
    rcv_rdy = 1'b0;
  endtask

  logic [N-1:0] rc, mc, hc;
  logic         ro, mo, ho;
  int           lat;
  int           seen;

  initial begin
    //            a         b         rnd   c_wrap    c_sat     ovf
    vecs[0]  = '{16'h0180, 16'h0200, 1'b0, 16'h0300, 16'h0300, 1'b0};
    vecs[1]  = '{16'hFF00, 16'h0080, 1'b0, 16'hFF80, 16'hFF80, 1'b0};
    vecs[2]  = '{16'h0001, 16'h0080, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{16'h0001, 16'h0080, 1'b1, 16'h0001, 16'h0001, 1'b0};
    vecs[4]  = '{16'h7F00, 16'h0200, 1'b0, 16'hFE00, 16'h7FFF, 1'b1};
    vecs[5]  = '{16'h0100, 16'h0100, 1'b0, 16'h0100, 16'h0100, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h7FFF, 1'b1};
    vecs[7]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h0080, 16'h8000, 1'b1};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{16'hFFFF, 16'h0080, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[10] = '{16'hFFFF, 16'h0080, 1'b1, 16'h0000, 16'h0000, 1'b0};

    // Reset state, observed before any clock edge.
    #2;
    check("rst_snd_rdy", 32'(snd_rdy), 32'd1);
    check("rst_rcv_val", 32'(rcv_val), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;

    // First op issues straight after release; the latency check confirms the first edge accepts.
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].rnd, 0, rc, ro, lat);
`ifdef FPMUL_ITER_RADIX_SAT_EN
      check($sformatf("vec%0d_c", i), 32'(rc), 32'(vecs[i].c_sat));
`else
      check($sformatf("vec%0d_c", i), 32'(rc), 32'(vecs[i].c_wrap));
`endif
      check($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
    end

    // Result held in DONE under backpressure.
    a = 16'h0180; b = 16'h0200; rnd = 1'b0; snd_val = 1'b1;
    @(posedge clk); #1;
    snd_val = 1'b0;
    lat = 1;
    while (!rcv_val && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_lat", 32'(lat), 32'(LAT));
    hc = c;
    ho = ovf;
    check("hold_c", 32'(hc), 32'h0300);
    check("hold_ovf", 32'(ho), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold%0d_rcv_val", i), 32'(rcv_val), 32'd1);
      check($sformatf("hold%0d_snd_rdy", i), 32'(snd_rdy), 32'd0);
      check($sformatf("hold%0d_c", i), 32'(c), 32'h0300);
      check($sformatf("hold%0d_ovf", i), 32'(ovf), 32'd0);
      @(posedge clk); #1;
    end
    rcv_rdy = 1'b1;
    @(posedge clk); #1;
    rcv_rdy = 1'b0;
    check("release_snd_rdy", 32'(snd_rdy), 32'd1);
    check("release_rcv_val", 32'(rcv_val), 32'd0);

    // Randomized operands against the reference model, with random consumer stalls.
    for (int i = 0; i < 150; i++) begin
      logic [N-1:0] ra, rb;
      logic         rr;
      ra = N'($urandom);
      rb = N'($urandom);
      rr = 1'($urandom);
      model(ra, rb, rr, mc, mo);
      do_op(ra, rb, rr, int'($urandom_range(0, 2)), rc, ro, lat);
      check($sformatf("rand%0d_c a=%h b=%h r=%0d", i, ra, rb, rr), 32'(rc), 32'(mc));
      check($sformatf("rand%0d_ovf", i), 32'(ro), 32'(mo));
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'(LAT));
    end

    // Reset pulsed mid-BUSY: outputs clear asynchronously and the operation is lost.
    do_op(16'h0180, 16'h0200, 1'b0, 0, rc, ro, lat);
    check("pre_reset_c", 32'(c), 32'h0300);
    a = 16'h7F00; b = 16'h0200; rnd = 1'b0; snd_val = 1'b1;
    @(posedge clk); #1;
    snd_val = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_snd_rdy", 32'(snd_rdy), 32'd1);
    check("midrst_rcv_val", 32'(rcv_val), 32'd0);
    check("midrst_c", 32'(c), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rcv_val) seen++;
    end
    check("midrst_no_rcv_val", 32'(seen), 32'd0);
    do_op(16'h0100, 16'h0100, 1'b0, 0, rc, ro, lat);
    check("post_rst_c", 32'(rc), 32'h0100);
    check("post_rst_ovf", 32'(ro), 32'd0);
    check("post_rst_lat", 32'(lat), 32'(LAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/fpmul_iter_radix.md
FPMUL_ITER_RADIX -- requirements
Module: fpmul_iter_radix

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result bit width.
REQ-002 SHALL have parameter D, default 16, meaning fractional bits, with 0 <= D < N.
REQ-003 SHALL have parameter SIGN, default 1, meaning 1 for two's-complement operands and 0 for unsigned.
REQ-004 SHALL have parameter K, default 4, meaning multiplier bits retired per cycle; N % K == 0 and 1 <= K <= N.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port snd_val, input, 1 bit, operands valid.
REQ-008 SHALL have port snd_rdy, output, 1 bit, ready to accept operands.
REQ-009 SHALL have ports a and b, inputs, N bits each, the multiplicand and multiplier.
REQ-010 SHALL have port rnd, input, 1 bit, sampled with the operands: 0 truncates, 1 rounds half-up.
REQ-011 SHALL have port rcv_val, output, 1 bit, result valid.
REQ-012 SHALL have port rcv_rdy, input, 1 bit, consumer ready.
REQ-013 SHALL have port c, output, N bits, the result.
REQ-014 SHALL have port ovf, output, 1 bit, overflow flag; meaningful only while rcv_val is 1.

Function
REQ-015 SHALL implement three states: IDLE, BUSY and DONE.
REQ-016 SHALL drive snd_rdy = 1 only in IDLE and rcv_val = 1 only in DONE.
REQ-017 SHALL, in IDLE when snd_val is 1, latch a, b and rnd, clear the accumulator and digit counter, and enter BUSY.
REQ-018 SHALL ignore operand inputs outside IDLE.
REQ-019 SHALL, in BUSY, add one partial product per cycle for K bits of b, least-significant digit first.
REQ-020 SHALL, when SIGN = 1, give the most-significant bit of b weight -2^(N-1).
REQ-021 SHALL keep a full 2N-bit accumulator, so no intermediate truncation occurs.
REQ-022 SHALL remain in BUSY for exactly N/K cycles, then enter DONE.
REQ-023 SHALL raise rcv_val N/K+1 cycles after the accepting edge.
REQ-024 SHALL form result P' = P + 2^(D-1) when rnd = 1 and D > 0, else P' = P, where P is the exact product.
REQ-025 SHALL form c from bits [N+D-1:D] of P'.
REQ-026 SHALL set ovf = 1 when P' shifted right by D does not fit N bits in the selected signedness.
REQ-027 SHALL, in DONE, hold c and ovf stable until rcv_rdy = 1.
REQ-028 SHALL, on a DONE cycle with rcv_rdy = 1, return to IDLE, so snd_rdy = 1 on the next cycle.
REQ-029 SHALL accept no new operands in the DONE handshake cycle, giving a minimum issue interval of N/K+2 cycles.
REQ-030 SHALL treat K = N as a single BUSY cycle.
REQ-031 SHALL treat D = 0 as integer multiply, where rnd has no effect.

Reset
REQ-032 SHALL, while reset_n = 0, immediately force state IDLE, snd_rdy = 1, rcv_val = 0, c = 0, ovf = 0, and clear the accumulator and counter.
REQ-033 SHALL discard any in-flight operation on reset assertion mid-BUSY or mid-DONE and produce no rcv_val for it.
REQ-034 SHALL release reset cleanly: the first accept is possible on the first rising edge after reset_n rises.

Configuration
REQ-035 SHALL, with macro FPMUL_ITER_RADIX_SAT_EN defined, clamp c on overflow (ovf = 1): to the maximum positive value for positive results, to the minimum negative value for negative results, and to all-ones for unsigned.
REQ-036 SHALL, with FPMUL_ITER_RADIX_SAT_EN undefined, wrap c to bits [N+D-1:D] of P'; ovf behaves identically in both builds.

Verification
REQ-037 SHALL cover: N=16, D=8, SIGN=1, K=4, a=0x0180, b=0x0200, rnd=0 -> c=0x0300, ovf=0, rcv_val 5 cycles after accept.
REQ-038 SHALL cover: a=0xFF00, b=0x0080 (-1.0 x 0.5) -> c=0xFF80, ovf=0.
REQ-039 SHALL cover: a=0x0001, b=0x0080 -> c=0x0000 with rnd=0, and c=0x0001 with rnd=1.
REQ-040 SHALL cover: a=0x7F00, b=0x0200 -> ovf=1, with c=0x7FFF under SAT_EN and c=0xFE00 without.
REQ-041 SHALL cover: rcv_rdy held 0 for 10 cycles in DONE -> c, ovf and rcv_val stable and snd_rdy=0; then rcv_rdy=1 -> snd_rdy=1 on the next cycle.
REQ-042 SHALL cover: reset_n pulsed low mid-BUSY -> outputs reset asynchronously, no rcv_val follows, and the next operation a=0x0100, b=0x0100 gives c=0x0100.
